// File: rtl/charge_countdown_timer.sv
// -----------------------------------------------------------------------------
// charge_countdown_timer
//
// Session countdown timer for the charging station. A purchased duration is
// loaded in BCD M:SS and counted down to 0:00. One second elapses for every
// TICKS_PER_SEC pulses of Tick. When the count reaches zero the timer raises
// Expired, which stays high until the next valid Load or Reset, and pulses
// Done for one cycle, so the charger controller can cut power.
//
// Parameters
//   TICKS_PER_SEC  Tick pulses per decremented second (>= 1)
//
// Ports
//   Clk            in   1   system clock, rising edge
//   Reset          in   1   synchronous, active-high reset
//   Load           in   1   strobe: latch LoadTime
//   LoadTime       in   12  BCD M:SS ([11:8] min 0-9, [7:4] tens 0-5, [3:0] sec 0-9)
//   Start          in   1   strobe: begin/resume countdown
//   Pause          in   1   strobe: halt countdown, hold value
//   Tick           in   1   time-base strobe
//   RemainingTime  out  12  BCD M:SS remaining (registered)
//   Running        out  1   high while counting
//   Expired        out  1   high once the countdown has reached 0:00
//   Done           out  1   one-cycle pulse when the countdown reaches 0:00
//   LoadError      out  1   one-cycle pulse when LoadTime was rejected
//
// Per-cycle priority: Reset > Load > Pause > Start > Tick.
// -----------------------------------------------------------------------------
module charge_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [11:0] LoadTime,
  input  logic        Start,
  input  logic        Pause,
  input  logic        Tick,
  output logic [11:0] RemainingTime,
  output logic        Running,
  output logic        Expired,
  output logic        Done,
  output logic        LoadError
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  state_t        state_q;
  logic [11:0]   time_q;
  logic [PW-1:0] pre_q;
  logic          running_q;
  logic          expired_q;
  logic          done_q;
  logic          load_error_q;

  logic          load_valid;
  logic [11:0]   dec_d;

  // Load validation and one-second BCD decrement of the current count.
  always_comb begin
    load_valid = (LoadTime[11:8] <= 4'd9) && (LoadTime[7:4] <= 4'd5) &&
                 (LoadTime[3:0] <= 4'd9);
    dec_d = 12'h000;
    if (time_q[3:0] != 4'd0) begin
      dec_d = {time_q[11:4], time_q[3:0] - 4'd1};
    end else if (time_q[7:4] != 4'd0) begin
      dec_d = {time_q[11:8], time_q[7:4] - 4'd1, 4'd9};
    end else if (time_q[11:8] != 4'd0) begin
      dec_d = {time_q[11:8] - 4'd1, 4'd5, 4'd9};
    end
    // 0:00 stays 0:00; never wraps below zero.
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      time_q       <= 12'h000;
      pre_q        <= '0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
      done_q       <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      load_error_q <= 1'b0;
      if (Load) begin
        // A Load always consumes the cycle, so a coincident Tick is dropped.
        if (!load_valid) begin
          load_error_q <= 1'b1;
        end else begin
          time_q    <= LoadTime;
          pre_q     <= '0;
          running_q <= 1'b0;
          expired_q <= 1'b0;
          state_q   <= (LoadTime == 12'h000) ? ST_IDLE : ST_LOADED;
        end
      end else if (Pause) begin
        // Prescaler is deliberately kept so a resumed second is not lengthened.
        if (state_q == ST_RUNNING) begin
          state_q   <= ST_PAUSED;
          running_q <= 1'b0;
        end
      end else if (Start) begin
        if (state_q == ST_LOADED || state_q == ST_PAUSED) begin
          state_q   <= ST_RUNNING;
          running_q <= 1'b1;
        end
      end else if (Tick && state_q == ST_RUNNING) begin
        if (pre_q == PRE_LAST) begin
          pre_q  <= '0;
          time_q <= dec_d;
          if (dec_d == 12'h000) begin
            state_q   <= ST_EXPIRED;
            running_q <= 1'b0;
            expired_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  assign RemainingTime = time_q;
  assign Running       = running_q;
  assign Expired       = expired_q;
  assign Done          = done_q;
  assign LoadError     = load_error_q;

endmodule

// File: tb/tb_charge_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_charge_countdown_timer
//
// Drives two timers from the same stimulus: one with one Tick per second and
// one with three. A model keeps the remaining time as a plain count of seconds
// and converts it to BCD for comparison; every cycle all outputs of both
// instances are compared with it. Directed literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_charge_countdown_timer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Load = 1'b0;
  logic [11:0] LoadTime = 12'h000;
  logic        Start = 1'b0;
  logic        Pause = 1'b0;
  logic        Tick = 1'b0;

  logic [11:0] a_rem, b_rem;
  logic        a_run, a_exp, a_done, a_lerr;
  logic        b_run, b_exp, b_done, b_lerr;

  always #5 Clk = ~Clk;

  charge_countdown_timer #(.TICKS_PER_SEC(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .Load(Load), .LoadTime(LoadTime),
    .Start(Start), .Pause(Pause), .Tick(Tick),
    .RemainingTime(a_rem), .Running(a_run), .Expired(a_exp),
    .Done(a_done), .LoadError(a_lerr)
  );

  charge_countdown_timer #(.TICKS_PER_SEC(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .Load(Load), .LoadTime(LoadTime),
    .Start(Start), .Pause(Pause), .Tick(Tick),
    .RemainingTime(b_rem), .Running(b_run), .Expired(b_exp),
    .Done(b_done), .LoadError(b_lerr)
  );

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 loaded, 2 running, 3 paused, 4 expired.
  int m_st   [2];
  int m_secs [2];
  int m_pre  [2];
  bit m_done [2];
  bit m_lerr [2];
  int m_tps  [2] = '{1, 3};

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int secs);
    int m, r;
    m = secs / 60;
    r = secs % 60;
    return {4'(m), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic model_step(input int k);
    logic [11:0] v;
    int m, t, s;
    v = LoadTime;
    m = int'(v[11:8]);
    t = int'(v[7:4]);
    s = int'(v[3:0]);
    m_done[k] = 1'b0;
    m_lerr[k] = 1'b0;
    if (Reset) begin
      m_st[k] = 0; m_secs[k] = 0; m_pre[k] = 0;
    end else if (Load) begin
      if (m > 9 || t > 5 || s > 9) begin
        m_lerr[k] = 1'b1;
      end else begin
        m_secs[k] = m * 60 + t * 10 + s;
        m_pre[k]  = 0;
        m_st[k]   = (m_secs[k] == 0) ? 0 : 1;
      end
    end else if (Pause) begin
      if (m_st[k] == 2) m_st[k] = 3;
    end else if (Start) begin
      if (m_st[k] == 1 || m_st[k] == 3) m_st[k] = 2;
    end else if (Tick && m_st[k] == 2) begin
      if (m_pre[k] == m_tps[k] - 1) begin
        m_pre[k] = 0;
        if (m_secs[k] > 0) m_secs[k]--;
        if (m_secs[k] == 0) begin
          m_st[k]   = 4;
          m_done[k] = 1'b1;
        end
      end else begin
        m_pre[k]++;
      end
    end
  endtask

  task automatic compare_all();
    chk("a rem",  a_rem,  to_bcd(m_secs[0]));
    chk("a run",  a_run,  12'(m_st[0] == 2));
    chk("a exp",  a_exp,  12'(m_st[0] == 4));
    chk("a done", a_done, 12'(m_done[0]));
    chk("a lerr", a_lerr, 12'(m_lerr[0]));
    chk("b rem",  b_rem,  to_bcd(m_secs[1]));
    chk("b run",  b_run,  12'(m_st[1] == 2));
    chk("b exp",  b_exp,  12'(m_st[1] == 4));
    chk("b done", b_done, 12'(m_done[1]));
    chk("b lerr", b_lerr, 12'(m_lerr[1]));
  endtask

  // One clock: apply inputs, advance model, compare after the active edge.
  task automatic cyc(input bit rst, input bit ld, input logic [11:0] lt,
                     input bit st, input bit ps, input bit tk);
    Reset = rst; Load = ld; LoadTime = lt; Start = st; Pause = ps; Tick = tk;
    model_step(0);
    model_step(1);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic idle();              cyc(0, 0, 12'h000, 0, 0, 0); endtask
  task automatic do_reset();          cyc(1, 0, 12'h000, 0, 0, 0); endtask
  task automatic do_load(input logic [11:0] v); cyc(0, 1, v, 0, 0, 0); endtask
  task automatic do_start();          cyc(0, 0, 12'h000, 1, 0, 0); endtask
  task automatic do_pause();          cyc(0, 0, 12'h000, 0, 1, 0); endtask
  task automatic do_tick();           cyc(0, 0, 12'h000, 0, 0, 1); endtask

  initial begin
    // 1: reset, load 1:30, five seconds.
    do_reset();
    do_reset();
    chk("t1 reset rem", a_rem, 12'h000);
    chk("t1 reset flags", {a_run, a_exp, a_done, a_lerr}, 12'h0);
    do_load(12'h130);
    do_start();
    for (int i = 0; i < 5; i++) do_tick();
    chk("t1 rem", a_rem, 12'h125);
    chk("t1 run", a_run, 12'h1);

    // 2: double borrow.
    do_load(12'h200);
    chk("t2 loaded rem", a_rem, 12'h200);
    chk("t2 loaded run", a_run, 12'h0);
    do_start();
    do_tick();
    chk("t2 borrow", a_rem, 12'h159);
    do_tick();
    chk("t2 next", a_rem, 12'h158);

    // 3: expiry.
    do_load(12'h002);
    do_start();
    do_tick();
    chk("t3 one", a_rem, 12'h001);
    do_tick();
    chk("t3 zero", a_rem, 12'h000);
    chk("t3 done", a_done, 12'h1);
    chk("t3 expired", a_exp, 12'h1);
    chk("t3 run", a_run, 12'h0);
    idle();
    chk("t3 done pulse", a_done, 12'h0);
    chk("t3 expired held", a_exp, 12'h1);
    do_tick();
    do_start();
    do_tick();
    chk("t3 frozen rem", a_rem, 12'h000);
    chk("t3 frozen exp", a_exp, 12'h1);
    do_load(12'h0A0);
    chk("t3 bad load keeps exp", a_exp, 12'h1);

    // 4: pause holds value.
    do_load(12'h046);
    chk("t4 load clears exp", a_exp, 12'h0);
    do_start();
    do_tick();
    chk("t4 at 045", a_rem, 12'h045);
    do_pause();
    for (int i = 0; i < 10; i++) do_tick();
    chk("t4 paused rem", a_rem, 12'h045);
    chk("t4 paused run", a_run, 12'h0);
    do_start();
    do_tick();
    chk("t4 resumed", a_rem, 12'h044);

    // 5: rejected loads, zero load.
    do_load(12'h070);
    chk("t5 lerr", a_lerr, 12'h1);
    chk("t5 rem kept", a_rem, 12'h044);
    chk("t5 run kept", a_run, 12'h1);
    idle();
    chk("t5 lerr pulse", a_lerr, 12'h0);
    do_load(12'hA00);
    chk("t5 lerr min", a_lerr, 12'h1);
    do_load(12'h00A);
    chk("t5 lerr sec", a_lerr, 12'h1);
    do_load(12'h000);
    chk("t5 zero rem", a_rem, 12'h000);
    chk("t5 zero run", a_run, 12'h0);
    do_start();
    do_tick();
    chk("t5 start ignored", a_run, 12'h0);

    // 6: three ticks per second (instance b).
    do_load(12'h010);
    do_start();
    do_tick();
    do_tick();
    chk("t6 prescale hold", b_rem, 12'h010);
    do_tick();
    chk("t6 prescale dec", b_rem, 12'h009);
    do_tick();
    do_pause();
    do_start();
    do_tick();
    chk("t6 pre kept", b_rem, 12'h009);
    do_tick();
    chk("t6 pre resumed", b_rem, 12'h008);
    cyc(0, 1, 12'h020, 0, 0, 1);
    chk("t6 load wins", b_rem, 12'h020);
    chk("t6 load wins run", b_run, 12'h0);
    cyc(0, 1, 12'h030, 1, 1, 0);
    chk("t6 load over start", b_run, 12'h0);
    cyc(0, 0, 12'h000, 1, 0, 1);
    chk("t6 start over tick", b_rem, 12'h030);
    do_tick();
    do_tick();
    do_reset();
    chk("t6 reset rem", b_rem, 12'h000);
    chk("t6 reset flags", {b_run, b_exp, b_done, b_lerr}, 12'h0);

    // Long countdown across the minute boundary to expiry.
    do_load(12'h105);
    do_start();
    for (int i = 0; i < 66; i++) do_tick();
    chk("long expired", a_exp, 12'h1);
    for (int i = 0; i < 130; i++) do_tick();
    chk("long b expired", b_exp, 12'h1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
